pc_redirect_unit: RTL and testbench

- EX-stage control-flow resolver and PC register owner; the producer side of the next-PC interface.
- Resolves branch/jump instructions in EX and drives NPCOp to the combinational next-PC generator.
- Takes the generator's result back as npc_in and registers it as the fetch PC.
- Issues IF/ID and ID/EX flushes, and blanks wrong-path EX slots for a fixed window after each redirect.

---
 rtl/pc_redirect_unit_pkg.sv | 25 ++
 rtl/pc_redirect_unit_branch_cmp.sv | 38 +++
 rtl/pc_redirect_unit.sv | 186 ++++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg
//   Shared encodings for the EX-stage redirect logic:
//   - NPCOp values driven to the combinational next-PC generator
//   - B-type funct3 condition codes
//   - redirect FSM state type
package pc_redirect_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } redirect_state_e;

endpackage

// File: rtl/pc_redirect_unit_branch_cmp.sv
// pc_redirect_unit_branch_cmp
//   Combinational B-type condition evaluator.
//   Ports:
//     i_funct3 [2:0]  branch condition code
//     i_rs1    [31:0] forwarded rs1
//     i_rs2    [31:0] forwarded rs2
//     o_taken         condition holds (010/011 are never taken)
module pc_redirect_unit_branch_cmp
  import pc_redirect_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_taken
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_rs1 == i_rs2);
  assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
  assign w_lt_u = (i_rs1 < i_rs2);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = !w_eq;
      F3_BLT:  o_taken = w_lt_s;
      F3_BGE:  o_taken = !w_lt_s;
      F3_BLTU: o_taken = w_lt_u;
      F3_BGEU: o_taken = !w_lt_u;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   EX-stage control-flow resolver and fetch-PC register owner. Drives NPCOp
//   to the next-PC generator, registers its result as the fetch PC, flushes
//   IF/ID and ID/EX on a redirect, and ignores EX for SQUASH_CYCLES cycles
//   afterwards so wrong-path instructions cannot redirect again.
//
//   Optional feature macro: PC_REDIRECT_STATS_EN (branch/taken/jump counters).
//
//   Ports:
//     clk, rstn                  clock, async active-low reset
//     stall                      hold the PC (a redirect overrides it)
//     ex_valid/ex_branch/ex_jal/ex_jalr/ex_funct3/ex_rs1/ex_rs2
//                                EX-stage instruction info
//     npc_in       [31:0]        next PC from the generator
//     npc_op       [2:0]         NPCOp (combinational)
//     pc_out       [31:0]        registered fetch PC
//     flush_ifid, flush_idex     pipeline flushes (combinational)
//     misalign_err               sticky misaligned redirect target
//     stat_clr, stat_branch, stat_taken, stat_jump   (macro only)
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] npc_in,
  output logic [2:0]  npc_op,
  output logic [31:0] pc_out,
  output logic        flush_ifid,
  output logic        flush_idex,
`ifdef PC_REDIRECT_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stat_branch,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_jump,
`endif
  output logic        misalign_err
);

  // Counter load value: the redirect cycle itself is not counted, so a
  // window of N cycles loads N-1 and leaves SQUASH after the cnt==0 cycle.
  localparam logic [2:0] SQ_LOAD = (SQUASH_CYCLES == 0) ? 3'd0
                                                        : 3'(SQUASH_CYCLES - 1);

  redirect_state_e r_state;
  redirect_state_e w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic [31:0]     r_pc;
  logic            r_misalign;

  logic w_active;
  logic w_taken;
  logic w_redirect;
  logic w_br_taken;

  pc_redirect_unit_branch_cmp u_branch_cmp (
    .i_funct3 (ex_funct3),
    .i_rs1    (ex_rs1),
    .i_rs2    (ex_rs2),
    .o_taken  (w_taken)
  );

  assign w_active = (r_state == ST_RUN) && ex_valid;

  // Priority JALR > JAL > BRANCH; the branch compare is only consulted when
  // neither jump flag is set.
  always_comb begin
    npc_op     = NPC_PLUS4;
    w_redirect = 1'b0;
    w_br_taken = 1'b0;
    if (w_active) begin
      if (ex_jalr) begin
        npc_op     = NPC_JALR;
        w_redirect = 1'b1;
      end else if (ex_jal) begin
        npc_op     = NPC_JUMP;
        w_redirect = 1'b1;
      end else if (ex_branch && w_taken) begin
        npc_op     = NPC_BRANCH;
        w_redirect = 1'b1;
        w_br_taken = 1'b1;
      end
    end
  end

  assign flush_ifid = w_redirect;
  assign flush_idex = w_redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_redirect && (SQUASH_CYCLES != 0)) begin
          w_state_nxt = ST_SQUASH;
          w_cnt_nxt   = SQ_LOAD;
        end
      end
      ST_SQUASH: begin
        // Counts down regardless of stall: the window is wall-clock cycles.
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc <= {npc_in[31:2], 2'b00};
        if (npc_in[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end else if (!stall) begin
        r_pc <= npc_in;
      end
    end
  end

  assign pc_out       = r_pc;
  assign misalign_err = r_misalign;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] r_stat_branch;
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_jump;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_branch <= 32'd0;
      r_stat_taken  <= 32'd0;
      r_stat_jump   <= 32'd0;
    end else if (stat_clr) begin
      r_stat_branch <= 32'd0;
      r_stat_taken  <= 32'd0;
      r_stat_jump   <= 32'd0;
    end else begin
      if (w_active && ex_branch) begin
        r_stat_branch <= r_stat_branch + 32'd1;
      end
      if (w_br_taken) begin
        r_stat_taken <= r_stat_taken + 32'd1;
      end
      if (w_active && (ex_jal || ex_jalr)) begin
        r_stat_jump <= r_stat_jump + 32'd1;
      end
    end
  end

  assign stat_branch = r_stat_branch;
  assign stat_taken  = r_stat_taken;
  assign stat_jump   = r_stat_jump;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural model tracks the PC, the remaining squash window and the
//   sticky error; a compare process checks the DUT against it every cycle.
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          SQ     = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, npc_in;
  logic [2:0]  npc_op;
  logic [31:0] pc_out;
  logic        flush_ifid, flush_idex, misalign_err;
`ifdef PC_REDIRECT_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_branch, stat_taken, stat_jump;
`endif

  pc_redirect_unit #(.RESET_PC(RST_PC), .SQUASH_CYCLES(SQ)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_branch    (ex_branch),
    .ex_jal       (ex_jal),
    .ex_jalr      (ex_jalr),
    .ex_funct3    (ex_funct3),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .npc_in       (npc_in),
    .npc_op       (npc_op),
    .pc_out       (pc_out),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
`ifdef PC_REDIRECT_STATS_EN
    .stat_clr     (stat_clr),
    .stat_branch  (stat_branch),
    .stat_taken   (stat_taken),
    .stat_jump    (stat_jump),
`endif
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  int          m_sq;   // cycles of EX still to be ignored
  logic        m_mis;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] m_sb, m_st, m_sj;
`endif

  function automatic logic cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_op();
    if (m_sq != 0 || !ex_valid) return NPC_PLUS4;
    if (ex_jalr) return NPC_JALR;
    if (ex_jal) return NPC_JUMP;
    if (ex_branch && cond(ex_funct3, ex_rs1, ex_rs2)) return NPC_BRANCH;
    return NPC_PLUS4;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_pc  = RST_PC;
        m_sq  = 0;
        m_mis = 1'b0;
`ifdef PC_REDIRECT_STATS_EN
        m_sb = 0; m_st = 0; m_sj = 0;
`endif
      end else begin
        logic [2:0] op;
        logic       redir;
        op    = exp_op();
        redir = (op != NPC_PLUS4);
`ifdef PC_REDIRECT_STATS_EN
        if (stat_clr) begin
          m_sb = 0; m_st = 0; m_sj = 0;
        end else begin
          if (m_sq == 0 && ex_valid && ex_branch) m_sb = m_sb + 1;
          if (op == NPC_BRANCH) m_st = m_st + 1;
          if (op == NPC_JUMP || op == NPC_JALR) m_sj = m_sj + 1;
        end
`endif
        if (redir && npc_in[1:0] != 2'b00) m_mis = 1'b1;
        if (redir)       m_pc = npc_in & 32'hFFFF_FFFC;
        else if (!stall) m_pc = npc_in;
        if (m_sq > 0)    m_sq = m_sq - 1;
        else if (redir)  m_sq = SQ;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [2:0] op;
        op = exp_op();
        chk("npc_op",     {29'd0, npc_op},     {29'd0, op});
        chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, op != NPC_PLUS4});
        chk("flush_idex", {31'd0, flush_idex}, {31'd0, op != NPC_PLUS4});
        chk("pc_out",     pc_out,              m_pc);
        chk("misalign",   {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef PC_REDIRECT_STATS_EN
        chk("stat_branch", stat_branch, m_sb);
        chk("stat_taken",  stat_taken,  m_st);
        chk("stat_jump",   stat_jump,   m_sj);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
    ex_funct3 = 3'd0; ex_rs1 = 0; ex_rs2 = 0;
`ifdef PC_REDIRECT_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1; ex_branch = 1; ex_jal = 0; ex_jalr = 0;
    ex_funct3 = f; ex_rs1 = a; ex_rs2 = b;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rstn = 0;
    idle();
    npc_in = 0;
    chk_en = 1;
    tick(); tick();
    rstn = 1;
    #2;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_op", {29'd0, npc_op}, {29'd0, NPC_PLUS4});
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    npc_in = 32'h4;
    tick(); #2; chk("run_pc4", pc_out, 32'h4);
    npc_in = 32'h8;
    tick(); #2; chk("run_pc8", pc_out, 32'h8);

    // BEQ taken, then two squashed cycles with a forced taken branch
    br(F3_BEQ, 5, 5); npc_in = 32'h100;
    #1;
    chk("beq_op", {29'd0, npc_op}, {29'd0, NPC_BRANCH});
    chk("beq_fl", {30'd0, flush_ifid, flush_idex}, 32'd3);
    tick(); npc_in = 32'h104; #2;
    chk("beq_pc", pc_out, 32'h100);
    chk("sq1_op", {29'd0, npc_op}, {29'd0, NPC_PLUS4});
    chk("sq1_fl", {30'd0, flush_ifid, flush_idex}, 32'd0);
    tick(); npc_in = 32'h108; #2;
    chk("sq2_pc", pc_out, 32'h104);
    chk("sq2_op", {29'd0, npc_op}, {29'd0, NPC_PLUS4});
    tick(); idle(); npc_in = 32'h10C; #2;
    chk("sq_end_pc", pc_out, 32'h108);

    // signed vs unsigned compares
    br(F3_BLT, 32'hFFFF_FFFF, 1); npc_in = 32'h300; #1;
    chk("blt_op", {29'd0, npc_op}, {29'd0, NPC_BRANCH});
    tick(); idle(); tick(); tick();
    br(F3_BLTU, 32'hFFFF_FFFF, 1); #1;
    chk("bltu_op", {29'd0, npc_op}, {29'd0, NPC_PLUS4});
    chk("bltu_fl", {30'd0, flush_ifid, flush_idex}, 32'd0);
    tick();
    br(F3_BGEU, 32'hFFFF_FFFF, 1); #1;
    chk("bgeu_op", {29'd0, npc_op}, {29'd0, NPC_BRANCH});
    tick(); idle(); tick(); tick();

    // stall together with JAL: redirect wins; then stall alone holds
    stall = 1; ex_valid = 1; ex_jal = 1; npc_in = 32'h40; #1;
    chk("jal_op", {29'd0, npc_op}, {29'd0, NPC_JUMP});
    tick(); idle(); stall = 1; npc_in = 32'h1234; #2;
    chk("jal_pc", pc_out, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      chk("stall_hold", pc_out, 32'h40);
    end
    stall = 0;

    // misaligned JALR target
    ex_valid = 1; ex_jalr = 1; npc_in = 32'h203; #1;
    chk("jalr_op", {29'd0, npc_op}, {29'd0, NPC_JALR});
    tick(); idle(); npc_in = 32'h204; #2;
    chk("jalr_pc", pc_out, 32'h200);
    chk("mis_set", {31'd0, misalign_err}, 32'd1);
    tick(); tick();
    ex_valid = 1; ex_jal = 1; npc_in = 32'h80;
    tick(); idle(); #2;
    chk("mis_pc", pc_out, 32'h80);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
    tick();
    // reset while still inside the squash window
    rstn = 0; #2;
    chk("rst2_pc", pc_out, RST_PC);
    chk("rst2_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst2_op", {29'd0, npc_op}, {29'd0, NPC_PLUS4});
    tick(); rstn = 1;

    // counters: 3 RUN branches (2 taken), 1 branch in SQUASH, 1 JAL
    br(F3_BEQ, 7, 7); npc_in = 32'h500; #1;
    chk("rst2_run_op", {29'd0, npc_op}, {29'd0, NPC_BRANCH});
    tick(); npc_in = 32'h504;
    tick(); idle();
    tick();
    br(F3_BNE, 3, 3);
    tick();
    br(F3_BLTU, 1, 2); npc_in = 32'h600;
    tick(); idle(); tick(); tick();
    ex_valid = 1; ex_jal = 1; npc_in = 32'h700;
    tick(); idle(); tick(); tick(); #2;
`ifdef PC_REDIRECT_STATS_EN
    chk("st_branch", stat_branch, 32'd3);
    chk("st_taken",  stat_taken,  32'd2);
    chk("st_jump",   stat_jump,   32'd1);
    stat_clr = 1;
    tick(); stat_clr = 0; #2;
    chk("st_clr", stat_branch | stat_taken | stat_jump, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rstn      = ($urandom_range(0, 199) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      ex_valid  = rstn && ($urandom_range(0, 3) != 0);
      ex_branch = ($urandom_range(0, 1) == 1);
      ex_jal    = ($urandom_range(0, 5) == 0);
      ex_jalr   = ($urandom_range(0, 5) == 0);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_rs1    = pick();
      ex_rs2    = pick();
      npc_in    = $urandom;
      if ($urandom_range(0, 7) != 0) npc_in[1:0] = 2'b00;
`ifdef PC_REDIRECT_STATS_EN
      stat_clr  = ($urandom_range(0, 31) == 0);
`endif
    end
    tick();
    rstn = 1;
    idle();
    tick(); tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
